// File: rtl/prim_max_tree_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prim_max_tree_pkg
//  Description : Shared types and compare helper for the arg-max/arg-min
//                tree primitives (also intended for future sort/select prims).
//  Revision    : 1.0 - initial release
// ============================================================================
package prim_max_tree_pkg;

    typedef enum logic {
        CmpMax = 1'b0,
        CmpMin = 1'b1
    } cmp_mode_e;

    // Operands are widened to this width by the caller (sign- or zero-extended)
    // so one helper serves every value width up to 64 bits.
    localparam int c_CMP_MAX_W = 64;

    // Strict "a beats b": greater-than for CmpMax, less-than for CmpMin.
    // Strictness is what makes the lower index win on equal values.
    function automatic logic better(input logic [c_CMP_MAX_W-1:0] a,
                                    input logic [c_CMP_MAX_W-1:0] b,
                                    input cmp_mode_e              mode,
                                    input logic                   signed_cmp);
        logic gt;
        logic lt;
        if (signed_cmp) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return (mode == CmpMax) ? gt : lt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prim_max_tree_node.sv
`default_nettype none
// ============================================================================
//  Module      : prim_max_tree_node
//  Description : Combinational two-input compare-select on (vld, idx, value).
//                Child 0 is the lower-index child and wins ties and the
//                both-invalid case.
//  Revision    : 1.0 - initial release
// ============================================================================
module prim_max_tree_node
    import prim_max_tree_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IDX_W  = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic             i_vld0,
    input  logic [IDX_W-1:0] i_idx0,
    input  logic [WIDTH-1:0] i_val0,
    input  logic             i_vld1,
    input  logic [IDX_W-1:0] i_idx1,
    input  logic [WIDTH-1:0] i_val1,
    input  cmp_mode_e        i_mode,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx,
    output logic [WIDTH-1:0] o_val
);

    logic [c_CMP_MAX_W-1:0] w_ext0;
    logic [c_CMP_MAX_W-1:0] w_ext1;
    logic                   w_pick1;

    // Widen both operands for the shared helper, then choose a child
    always_comb begin
        w_ext0  = SIGNED ? c_CMP_MAX_W'($signed(i_val0)) : c_CMP_MAX_W'(i_val0);
        w_ext1  = SIGNED ? c_CMP_MAX_W'($signed(i_val1)) : c_CMP_MAX_W'(i_val1);
        w_pick1 = (~i_vld0 & i_vld1) |
                  (i_vld0 & i_vld1 & better(w_ext1, w_ext0, i_mode, SIGNED));
        o_vld   = i_vld0 | i_vld1;
        o_idx   = w_pick1 ? i_idx1 : i_idx0;
        o_val   = w_pick1 ? i_val1 : i_val0;
    end

endmodule
`default_nettype wire

// File: rtl/prim_max_tree_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : prim_max_tree_pipe
//  Description : Pipelined, elastic arg-max/arg-min tree over NUM_SRC masked
//                entries. A stage register follows every REG_EVERY levels
//                (plus the root); REG_EVERY=0 gives a purely combinational tree.
//  Revision    : 1.0 - initial release
// ============================================================================
module prim_max_tree_pipe
    import prim_max_tree_pkg::*;
#(
    parameter int NUM_SRC   = 32,
    parameter int WIDTH     = 8,
    parameter int REG_EVERY = 1,
    parameter bit SIGNED    = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  cmp_mode_e                  mode_i,
    input  logic [NUM_SRC*WIDTH-1:0]   values_i,
    input  logic [NUM_SRC-1:0]         valid_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           value_o,
    output logic [$clog2(NUM_SRC)-1:0] idx_o,
    output logic                       any_valid_o
);

    localparam int c_IDX_W  = $clog2(NUM_SRC);
    localparam int c_LEVELS = c_IDX_W;
    localparam int c_LEAVES = 1 << c_LEVELS;
    localparam int c_DIV    = (REG_EVERY > 0) ? REG_EVERY : 1;
    localparam int c_STAGES = (REG_EVERY > 0) ? (c_LEVELS + REG_EVERY - 1) / REG_EVERY : 0;
    localparam int c_STG_N  = (c_STAGES > 0) ? c_STAGES : 1;

    logic [c_STG_N-1:0] w_load;
    logic               w_root_vld;
    logic [c_IDX_W-1:0] w_root_idx;
    logic [WIDTH-1:0]   w_root_val;

    // Level 0 holds the (padded) leaves; level c_LEVELS holds the single root
    for (genvar l = 0; l <= c_LEVELS; l++) begin : g_lvl
        localparam int c_CNT = c_LEAVES >> l;

        logic [c_CNT-1:0]   w_vld;
        logic [c_IDX_W-1:0] w_idx [c_CNT];
        logic [WIDTH-1:0]   w_val [c_CNT];
        cmp_mode_e          w_mode;

        if (l == 0) begin : g_leaves
            assign w_mode = mode_i;
            for (genvar k = 0; k < c_CNT; k++) begin : g_leaf
                if (k < NUM_SRC) begin : g_src
                    assign w_vld[k] = valid_i[k];
                    assign w_idx[k] = c_IDX_W'(k);
                    assign w_val[k] = values_i[k*WIDTH +: WIDTH];
                end else begin : g_pad
                    assign w_vld[k] = 1'b0;
                    assign w_idx[k] = '0;
                    assign w_val[k] = '0;
                end
            end
        end else begin : g_nodes
            localparam bit c_REG = (REG_EVERY > 0) && (((l % c_DIV) == 0) || (l == c_LEVELS));
            localparam int c_STG = (l - 1) / c_DIV;

            logic [c_CNT-1:0]   w_sel_vld;
            logic [c_IDX_W-1:0] w_sel_idx [c_CNT];
            logic [WIDTH-1:0]   w_sel_val [c_CNT];

            for (genvar k = 0; k < c_CNT; k++) begin : g_node
                prim_max_tree_node #(
                    .WIDTH  (WIDTH),
                    .IDX_W  (c_IDX_W),
                    .SIGNED (SIGNED)
                ) u_node (
                    .i_vld0 (g_lvl[l-1].w_vld[2*k]),
                    .i_idx0 (g_lvl[l-1].w_idx[2*k]),
                    .i_val0 (g_lvl[l-1].w_val[2*k]),
                    .i_vld1 (g_lvl[l-1].w_vld[2*k+1]),
                    .i_idx1 (g_lvl[l-1].w_idx[2*k+1]),
                    .i_val1 (g_lvl[l-1].w_val[2*k+1]),
                    .i_mode (g_lvl[l-1].w_mode),
                    .o_vld  (w_sel_vld[k]),
                    .o_idx  (w_sel_idx[k]),
                    .o_val  (w_sel_val[k])
                );
            end

            if (c_REG) begin : g_reg
                logic [c_CNT-1:0]   r_vld;
                logic [c_IDX_W-1:0] r_idx [c_CNT];
                logic [WIDTH-1:0]   r_val [c_CNT];
                cmp_mode_e          r_mode;

                // Capture this level's winners (and the mode) when the owning stage loads
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_vld  <= '0;
                        r_mode <= CmpMax;
                        for (int j = 0; j < c_CNT; j++) begin
                            r_idx[j] <= '0;
                            r_val[j] <= '0;
                        end
                    end else if (w_load[c_STG]) begin
                        r_vld  <= w_sel_vld;
                        r_mode <= g_lvl[l-1].w_mode;
                        r_idx  <= w_sel_idx;
                        r_val  <= w_sel_val;
                    end
                end

                assign w_vld  = r_vld;
                assign w_idx  = r_idx;
                assign w_val  = r_val;
                assign w_mode = r_mode;
            end else begin : g_comb
                assign w_vld  = w_sel_vld;
                assign w_idx  = w_sel_idx;
                assign w_val  = w_sel_val;
                assign w_mode = g_lvl[l-1].w_mode;
            end
        end

        if (l == c_LEVELS) begin : g_root
            assign w_root_vld = w_vld[0];
            assign w_root_idx = w_idx[0];
            assign w_root_val = w_val[0];
        end
    end

    if (c_STAGES > 0) begin : g_pipe
        logic [c_STAGES-1:0] r_stg_vld;
        logic [c_STAGES-1:0] w_rdy;
        logic                w_acc;
        logic                w_prev;

        // Elastic ready chain: a stage can take data if it is empty or anything downstream moves
        always_comb begin
            w_rdy  = '0;
            w_load = '0;
            w_acc  = out_ready_i;
            for (int s = c_STAGES - 1; s >= 0; s--) begin
                w_acc    = w_acc | ~r_stg_vld[s];
                w_rdy[s] = w_acc;
            end
            w_prev = in_valid_i;
            for (int s = 0; s < c_STAGES; s++) begin
                w_load[s] = w_rdy[s] & w_prev;
                w_prev    = r_stg_vld[s];
            end
        end

        // Stage-valid bits: hold when stalled, otherwise take the upstream valid
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_stg_vld <= '0;
            end else begin
                r_stg_vld <= (r_stg_vld & ~w_rdy) | w_load;
            end
        end

        assign in_ready_o  = w_rdy[0] & ~rst_i;
        assign out_valid_o = r_stg_vld[c_STAGES-1] & ~rst_i;
    end else begin : g_flow
        assign w_load      = '0;
        assign in_ready_o  = out_ready_i & ~rst_i;
        assign out_valid_o = in_valid_i & ~rst_i;
    end

    assign value_o     = rst_i ? '0 : w_root_val;
    assign idx_o       = rst_i ? '0 : w_root_idx;
    assign any_valid_o = w_root_vld & ~rst_i;

`ifndef SYNTHESIS
    if (NUM_SRC < 2) begin : g_bad_num_src
        $error("prim_max_tree_pipe: NUM_SRC must be >= 2");
    end

    if (c_STAGES > 0) begin : g_chk_stall
        a_stall_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (out_valid_o && !out_ready_i) |=>
            (rst_i || (out_valid_o && $stable(value_o) && $stable(idx_o) && $stable(any_valid_o))));
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prim_max_tree_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prim_max_tree_pipe
//  Description : Scoreboard bench for prim_max_tree_pipe (8 entries, 3-stage)
//                plus a combinational signed 5-entry instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prim_max_tree_pipe;
    import prim_max_tree_pkg::*;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int IW = 3;
    localparam int N2 = 5;

    typedef struct packed {
        logic [W-1:0]  val;
        logic [IW-1:0] idx;
        logic          any;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, in_valid, in_ready, out_valid, out_ready, any;
    cmp_mode_e      mode;
    logic [N*W-1:0] values;
    logic [N-1:0]   vmask;
    logic [W-1:0]   value;
    logic [IW-1:0]  idx;

    logic            rst2, in_valid2, in_ready2, out_valid2, out_ready2, any2;
    cmp_mode_e       mode2;
    logic [N2*W-1:0] values2;
    logic [N2-1:0]   vmask2;
    logic [W-1:0]    value2;
    logic [IW-1:0]   idx2;

    prim_max_tree_pipe #(.NUM_SRC(N), .WIDTH(W), .REG_EVERY(1), .SIGNED(1'b0)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .mode_i(mode), .values_i(values), .valid_i(vmask), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .value_o(value), .idx_o(idx), .any_valid_o(any)
    );

    prim_max_tree_pipe #(.NUM_SRC(N2), .WIDTH(W), .REG_EVERY(0), .SIGNED(1'b1)) u_dut_comb (
        .clk_i(clk), .rst_i(rst2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .mode_i(mode2), .values_i(values2), .valid_i(vmask2), .out_valid_o(out_valid2),
        .out_ready_i(out_ready2), .value_o(value2), .idx_o(idx2), .any_valid_o(any2)
    );

    res_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;
    bit   done   = 1'b0;

    // Reference: scan entries in index order, keep the strictly better valid one
    function automatic res_t ref_model(input int n, input bit sgn, input bit is_min,
                                       input logic [N*W-1:0] vals, input logic [N-1:0] msk);
        res_t         r;
        int           best = -1;
        int           bv   = 0;
        int           cur;
        logic [W-1:0] v;
        for (int i = 0; i < n; i++) begin
            if (msk[i]) begin
                v   = vals[i*W +: W];
                cur = sgn ? {{24{v[W-1]}}, v} : {24'd0, v};
                if (best < 0 || (is_min ? (cur < bv) : (cur > bv))) begin
                    best = i;
                    bv   = cur;
                end
            end
        end
        r.any = (best >= 0);
        r.idx = (best < 0) ? '0 : IW'(best);
        r.val = (best < 0) ? vals[W-1:0] : vals[best*W +: W];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Present one transaction and hold it until accepted; push its expected result
    task automatic send(input cmp_mode_e m, input logic [N*W-1:0] v,
                        input logic [N-1:0] k, input res_t e);
        int t = 0;
        mode = m; values = v; vmask = k; in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles, need 1", t);
        end else begin
            exp_q.push_back(e);
            n_acc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_rand();
        cmp_mode_e      m;
        logic [N*W-1:0] v;
        logic [N-1:0]   k;
        bit             narrow;
        narrow = 1'($urandom_range(0, 1));
        for (int i = 0; i < N; i++)
            v[i*W +: W] = narrow ? W'($urandom_range(0, 3)) : W'($urandom);
        k = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
        m = cmp_mode_e'($urandom_range(0, 1));
        send(m, v, k, ref_model(N, 1'b0, m == CmpMin, v, k));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: pop and compare on every output handshake; enforce hold under stall
    initial begin
        res_t e, now, held;
        bit   stalled = 1'b0;
        forever begin
            @(negedge clk);
            now = {value, idx, any};
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (!out_valid || now !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b res=0x%0h held 0x%0h", out_valid, now, held);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got res=0x%0h, none outstanding", now);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 32'(now), 32'(e));
                    end
                end
                stalled = out_valid && !out_ready;
                held    = now;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0]  v;
        logic [N2*W-1:0] v2;
        int              lat;
        int              base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = CmpMax; values = '0; vmask = '0;
        rst2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; mode2 = CmpMax; values2 = '0; vmask2 = '0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", {value, idx, any}, 0);
        check("ready_after_reset", in_ready, 1);

        // Directed: max with tie, masked min, empty mask
        @(posedge clk); #1;
        v = {8'd7, 8'd0, 8'd0, 8'd0, 8'd3, 8'd50, 8'd50, 8'd10};
        send(CmpMax, v, 8'hFF, {8'd50, 3'd1, 1'b1});
        send(CmpMin, v, 8'b1000_1001, {8'd3, 3'd3, 1'b1});
        v[7:0] = 8'hA5;
        send(cmp_mode_e'($urandom_range(0, 1)), v, 8'h00, {8'hA5, 3'd0, 1'b0});
        in_valid = 1'b0;
        drain();

        // Backpressure: 5 back-to-back with the sink stalled for 6 cycles
        @(posedge clk); #1;
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                repeat (5) send_rand();
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(negedge clk);
                check("accepts_while_stalled", n_acc - base, 3);
                check("in_ready_while_stalled", in_ready, 0);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with 3 in flight, then a fresh transaction's latency
        @(posedge clk); #1;
        repeat (3) send_rand();
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("in_ready_during_rst", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("no_stale_after_rst", {out_valid, any}, 0);
        @(posedge clk); #1;
        send_rand();
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency", lat, 3);
        repeat (5) @(negedge clk);
        check("flush_queue_empty", exp_q.size(), 0);

        // Randomized traffic with random sink readiness and input gaps
        @(posedge clk); #1;
        fork
            begin
                int gap;
                repeat (300) begin
                    gap = $urandom_range(0, 2);
                    if (gap != 0) begin
                        in_valid = 1'b0;
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Combinational signed 5-entry instance
        in_valid2 = 1'b1; out_ready2 = 1'b1;
        values2 = {8'd5, 8'd0, 8'h7F, 8'h80, 8'hFF}; vmask2 = 5'h1F; mode2 = CmpMin;
        #1;
        check("comb_valid", out_valid2, 1);
        check("comb_signed_min", {value2, idx2, any2}, {8'h80, 3'd1, 1'b1});
        mode2 = CmpMax;
        #1;
        check("comb_signed_max", {value2, idx2, any2}, {8'h7F, 3'd2, 1'b1});
        out_ready2 = 1'b0;
        #1;
        check("comb_ready_follows", in_ready2, 0);
        out_ready2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < N2; j++) v2[j*W +: W] = W'($urandom);
            values2 = v2;
            vmask2  = N2'($urandom);
            mode2   = cmp_mode_e'($urandom_range(0, 1));
            #1;
            check("comb_random", {value2, idx2, any2},
                  32'(ref_model(N2, 1'b1, mode2 == CmpMin, {24'd0, v2}, {3'd0, vmask2})));
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
